// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl -- exception / interrupt sequencer between MEM and CP0.
//
// Each IDLE cycle with a valid MEM instruction, the sequencer samples the
// instruction's exception flags and the pending interrupts (qualified by CP0
// Status/Cause). It picks one event by fixed priority and presents its code to
// CP0 for exactly one cycle. It then flushes the pipeline for FLUSH_CYCLES
// cycles and issues a one-cycle PC redirect to the handler vector, or to EPC
// for eret.
//
// Build option:
//   EXC_CTRL_TIMER_INT_EN  when defined, timer_int_i is ORed into IP7
//                          (Cause bit 15) before masking with IM7.
//
// Parameters:
//   FLUSH_CYCLES  cycles flush_o is held high (1..15)
//   VEC_OFFSET    handler offset appended to EBase[31:12]
//
// Ports:
//   clk               clock, rising edge
//   rst               asynchronous reset, active low
//   mem_valid_i       MEM holds a valid instruction
//   exc_flags_i       {eret, ades, ov, trap, syscall, inst_invalid, adel}
//   inst_addr_i       PC of the MEM instruction
//   in_delay_slot_i   MEM instruction sits in a delay slot
//   bad_addr_i        faulting address for adel/ades
//   status_i          CP0 Status (IE=0, EXL=1, IM=15:8)
//   cause_i           CP0 Cause (IP=15:8)
//   epc_i             CP0 EPC
//   ebase_i           CP0 EBase
//   timer_int_i       CP0 timer interrupt
//   excepttype_o      event code, nonzero for one cycle per event
//   exc_addr_o        captured instruction address
//   exc_delay_slot_o  captured delay-slot flag
//   exc_bad_addr_o    captured faulting address
//   flush_o           flush all pipeline stages
//   pc_we_o           one-cycle PC load strobe
//   new_pc_o          redirect target, valid while pc_we_o=1
//   busy_o            sequencer not idle
//   exc_count_o       events taken, saturating
// -----------------------------------------------------------------------------
module exc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [11:0] VEC_OFFSET   = 12'h180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [6:0]  exc_flags_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delay_slot_i,
  input  logic [31:0] bad_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  input  logic [31:0] ebase_i,
  input  logic        timer_int_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_addr_o,
  output logic        exc_delay_slot_o,
  output logic [31:0] exc_bad_addr_o,
  output logic        flush_o,
  output logic        pc_we_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o,
  output logic [15:0] exc_count_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] code_q;
  logic        is_eret_q;
  logic [31:0] exc_addr_q;
  logic        exc_ds_q;
  logic [31:0] exc_bad_q;
  logic [15:0] count_q;

  logic [7:0]  ip;
  logic        irq_pending;
  logic [31:0] event_code;
  logic        detect;

  // Interrupt qualification
`ifdef EXC_CTRL_TIMER_INT_EN
  assign ip = {cause_i[15] | timer_int_i, cause_i[14:8]};
`else
  assign ip = cause_i[15:8];
  logic unused_timer;
  assign unused_timer = timer_int_i;
`endif

  assign irq_pending = status_i[0] & ~status_i[1] & (|(ip & status_i[15:8]));

  // Status/Cause/EBase bits outside the fields this block interprets.
  logic unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[7:2],
                         cause_i[31:16], cause_i[7:0], ebase_i[11:0]};

  // Fixed-priority selection; interrupt beats every flag, eret is last.
  always_comb begin
    event_code = 32'h0;
    if (irq_pending)         event_code = 32'h1;
    else if (exc_flags_i[0]) event_code = 32'hf;  // adel
    else if (exc_flags_i[1]) event_code = 32'ha;  // inst_invalid
    else if (exc_flags_i[2]) event_code = 32'h8;  // syscall
    else if (exc_flags_i[3]) event_code = 32'hd;  // trap
    else if (exc_flags_i[4]) event_code = 32'hc;  // ov
    else if (exc_flags_i[5]) event_code = 32'hb;  // ades
    else if (exc_flags_i[6]) event_code = 32'he;  // eret
  end

  assign detect = (state_q == S_IDLE) && mem_valid_i && (event_code != 32'h0);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        if (detect) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = S_REDIRECT;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      code_q     <= 32'h0;
      is_eret_q  <= 1'b0;
      exc_addr_q <= 32'h0;
      exc_ds_q   <= 1'b0;
      exc_bad_q  <= 32'h0;
      count_q    <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (detect) begin
        code_q     <= event_code;
        is_eret_q  <= (event_code == 32'he);
        exc_addr_q <= inst_addr_i;
        exc_ds_q   <= in_delay_slot_i;
        exc_bad_q  <= bad_addr_i;
        if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      end
    end
  end

  // Outputs. The redirect target is formed from live EPC/EBase so that any
  // CP0 update triggered by the code in the first FLUSH cycle is seen.
  always_comb begin
    excepttype_o = 32'h0;
    flush_o      = 1'b0;
    pc_we_o      = 1'b0;
    new_pc_o     = 32'h0;
    busy_o       = (state_q != S_IDLE);
    if (state_q == S_FLUSH) begin
      flush_o = 1'b1;
      if (cnt_q == 4'd0) excepttype_o = code_q;
    end
    if (state_q == S_REDIRECT) begin
      pc_we_o  = 1'b1;
      new_pc_o = is_eret_q ? epc_i : {ebase_i[31:12], VEC_OFFSET};
    end
  end

  assign exc_addr_o       = exc_addr_q;
  assign exc_delay_slot_o = exc_ds_q;
  assign exc_bad_addr_o   = exc_bad_q;
  assign exc_count_o      = count_q;

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
  logic        clk;
  logic        rst;
  logic        mem_valid_i;
  logic [6:0]  exc_flags_i;
  logic [31:0] inst_addr_i;
  logic        in_delay_slot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [31:0] ebase_i;
  logic        timer_int_i;
  logic [31:0] excepttype_o;
  logic [31:0] exc_addr_o;
  logic        exc_delay_slot_o;
  logic [31:0] exc_bad_addr_o;
  logic        flush_o;
  logic        pc_we_o;
  logic [31:0] new_pc_o;
  logic        busy_o;
  logic [15:0] exc_count_o;

  int vectors = 0;
  int miscompares = 0;

  exc_ctrl #(.FLUSH_CYCLES(2), .VEC_OFFSET(12'h180)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .exc_flags_i(exc_flags_i),
    .inst_addr_i(inst_addr_i), .in_delay_slot_i(in_delay_slot_i),
    .bad_addr_i(bad_addr_i), .status_i(status_i), .cause_i(cause_i),
    .epc_i(epc_i), .ebase_i(ebase_i), .timer_int_i(timer_int_i),
    .excepttype_o(excepttype_o), .exc_addr_o(exc_addr_o),
    .exc_delay_slot_o(exc_delay_slot_o), .exc_bad_addr_o(exc_bad_addr_o),
    .flush_o(flush_o), .pc_we_o(pc_we_o), .new_pc_o(new_pc_o),
    .busy_o(busy_o), .exc_count_o(exc_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled at the negedge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    mem_valid_i     = 1'b0;
    exc_flags_i     = 7'h0;
    in_delay_slot_i = 1'b0;
    status_i        = 32'h0;
    cause_i         = 32'h0;
    timer_int_i     = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    inst_addr_i = 32'h0; bad_addr_i = 32'h0;
    epc_i = 32'h0; ebase_i = 32'h8000_0000;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({excepttype_o, exc_addr_o, exc_delay_slot_o, exc_bad_addr_o, flush_o,
         pc_we_o, new_pc_o, busy_o, exc_count_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got exc=%h addr=%h ds=%b bad=%h flush=%b we=%b npc=%h busy=%b cnt=%h, need all 0",
               excepttype_o, exc_addr_o, exc_delay_slot_o, exc_bad_addr_o, flush_o,
               pc_we_o, new_pc_o, busy_o, exc_count_o);
    end
    rst = 1'b1;
    cycle();
    $display("reset: outputs checked");
  endtask

  task automatic test_syscall();
    mem_valid_i = 1'b1; exc_flags_i = 7'b0000100;
    inst_addr_i = 32'h8000_0100; in_delay_slot_i = 1'b1; bad_addr_i = 32'h1234_5678;
    ebase_i = 32'h8000_0000;
    cycle();  // detection edge N; now in cycle N+1
    clear_inputs();
    vectors++;
    if (excepttype_o !== 32'h8 || flush_o !== 1'b1 || busy_o !== 1'b1 || pc_we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL syscall_n1: got exc=%h flush=%b busy=%b we=%b, need 8 1 1 0",
               excepttype_o, flush_o, busy_o, pc_we_o);
    end
    vectors++;
    if (exc_addr_o !== 32'h8000_0100 || exc_delay_slot_o !== 1'b1 ||
        exc_bad_addr_o !== 32'h1234_5678 || exc_count_o !== 16'd1) begin
      miscompares++;
      $display("FAIL syscall_capture: got addr=%h ds=%b bad=%h cnt=%0d, need 80000100 1 12345678 1",
               exc_addr_o, exc_delay_slot_o, exc_bad_addr_o, exc_count_o);
    end
    cycle();  // N+2
    vectors++;
    if (excepttype_o !== 32'h0 || flush_o !== 1'b1 || pc_we_o !== 1'b0) begin
      miscompares++;
      $display("FAIL syscall_n2: got exc=%h flush=%b we=%b, need 0 1 0",
               excepttype_o, flush_o, pc_we_o);
    end
    cycle();  // N+3 redirect
    vectors++;
    if (pc_we_o !== 1'b1 || new_pc_o !== 32'h8000_0180 || flush_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL syscall_redirect: got we=%b npc=%h flush=%b busy=%b, need 1 80000180 0 1",
               pc_we_o, new_pc_o, flush_o, busy_o);
    end
    cycle();  // N+4 idle
    vectors++;
    if (pc_we_o !== 1'b0 || new_pc_o !== 32'h0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL syscall_idle: got we=%b npc=%h busy=%b, need 0 0 0", pc_we_o, new_pc_o, busy_o);
    end
    $display("syscall: code/flush/redirect sequence checked");
  endtask

  task automatic test_interrupt_priority();
    mem_valid_i = 1'b1; exc_flags_i = 7'b0010000;  // ov
    status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
    inst_addr_i = 32'h8000_0300; ebase_i = 32'h9000_0000;
    cycle();
    clear_inputs();
    vectors++;
    if (excepttype_o !== 32'h1 || exc_count_o !== 16'd2) begin
      miscompares++;
      $display("FAIL irq_over_ov: got exc=%h cnt=%0d, need 1 2", excepttype_o, exc_count_o);
    end
    repeat (2) cycle();
    vectors++;
    if (pc_we_o !== 1'b1 || new_pc_o !== 32'h9000_0180) begin
      miscompares++;
      $display("FAIL irq_redirect: got we=%b npc=%h, need 1 90000180", pc_we_o, new_pc_o);
    end
    cycle();
    $display("interrupt+ov: code 1 checked");
  endtask

  task automatic test_masked_interrupt();
    // EXL=1 then IE=0: neither may start a sequence.
    mem_valid_i = 1'b1; status_i = 32'h0000_0403; cause_i = 32'h0000_0400;
    cycle();
    vectors++;
    if (busy_o !== 1'b0 || excepttype_o !== 32'h0) begin
      miscompares++;
      $display("FAIL irq_exl_masked: got busy=%b exc=%h, need 0 0", busy_o, excepttype_o);
    end
    status_i = 32'h0000_0400;
    cycle();
    vectors++;
    if (busy_o !== 1'b0 || excepttype_o !== 32'h0 || exc_count_o !== 16'd2) begin
      miscompares++;
      $display("FAIL irq_ie_masked: got busy=%b exc=%h cnt=%0d, need 0 0 2", busy_o, excepttype_o, exc_count_o);
    end
    clear_inputs();
    $display("masked interrupts: no event checked");
  endtask

  task automatic test_eret();
    mem_valid_i = 1'b1; exc_flags_i = 7'b1000000;
    epc_i = 32'h8000_0200; ebase_i = 32'h8000_0000;
    cycle();
    clear_inputs();
    vectors++;
    if (excepttype_o !== 32'he) begin
      miscompares++;
      $display("FAIL eret_code: got exc=%h, need e", excepttype_o);
    end
    repeat (2) cycle();
    vectors++;
    if (pc_we_o !== 1'b1 || new_pc_o !== 32'h8000_0200) begin
      miscompares++;
      $display("FAIL eret_redirect: got we=%b npc=%h, need 1 80000200", pc_we_o, new_pc_o);
    end
    cycle();
    // eret with a pending interrupt in the same cycle goes to the vector.
    mem_valid_i = 1'b1; exc_flags_i = 7'b1000000;
    status_i = 32'h0000_0801; cause_i = 32'h0000_0800;
    cycle();
    clear_inputs();
    vectors++;
    if (excepttype_o !== 32'h1) begin
      miscompares++;
      $display("FAIL eret_vs_irq_code: got exc=%h, need 1", excepttype_o);
    end
    repeat (2) cycle();
    vectors++;
    if (new_pc_o !== 32'h8000_0180) begin
      miscompares++;
      $display("FAIL eret_vs_irq_target: got npc=%h, need 80000180", new_pc_o);
    end
    cycle();
    $display("eret: code e and EPC redirect checked");
  endtask

  task automatic test_back_to_back();
    // Count is 4 here. Syscall held through FLUSH must be taken only once.
    mem_valid_i = 1'b1; exc_flags_i = 7'b0000100; inst_addr_i = 32'h8000_0400;
    cycle();  // N+1
    inst_addr_i = 32'h8000_0500;
    cycle();  // N+2, new syscall visible in FLUSH
    clear_inputs();
    vectors++;
    if (exc_count_o !== 16'd5 || exc_addr_o !== 32'h8000_0400 || excepttype_o !== 32'h0) begin
      miscompares++;
      $display("FAIL b2b_ignored: got cnt=%0d addr=%h exc=%h, need 5 80000400 0",
               exc_count_o, exc_addr_o, excepttype_o);
    end
    cycle();  // redirect
    mem_valid_i = 1'b1; exc_flags_i = 7'b0000001;  // adel, presented in REDIRECT
    cycle();  // back in IDLE; adel ignored in REDIRECT so nothing detected yet
    vectors++;
    if (busy_o !== 1'b0 || exc_count_o !== 16'd5) begin
      miscompares++;
      $display("FAIL b2b_redirect_ignored: got busy=%b cnt=%0d, need 0 5", busy_o, exc_count_o);
    end
    cycle();  // adel detected in the first IDLE cycle
    clear_inputs();
    vectors++;
    if (excepttype_o !== 32'hf || exc_count_o !== 16'd6) begin
      miscompares++;
      $display("FAIL b2b_next_event: got exc=%h cnt=%0d, need f 6", excepttype_o, exc_count_o);
    end
    repeat (3) cycle();
    $display("back-to-back: single count and earliest next event checked");
  endtask

  task automatic test_reset_midflush();
    int we_seen;
    mem_valid_i = 1'b1; exc_flags_i = 7'b0000100;
    cycle();
    clear_inputs();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({excepttype_o, exc_addr_o, flush_o, pc_we_o, new_pc_o, busy_o, exc_count_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_midflush: got exc=%h addr=%h flush=%b we=%b npc=%h busy=%b cnt=%0d, need all 0",
               excepttype_o, exc_addr_o, flush_o, pc_we_o, new_pc_o, busy_o, exc_count_o);
    end
    @(negedge clk);
    rst = 1'b1;
    we_seen = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (pc_we_o === 1'b1 || busy_o === 1'b1) we_seen++;
    end
    vectors++;
    if (we_seen !== 0) begin
      miscompares++;
      $display("FAIL reset_no_redirect: got %0d busy/pc_we cycles, need 0", we_seen);
    end
    $display("reset mid-flush: abort checked");
  endtask

  task automatic test_timer_int();
    mem_valid_i = 1'b1; status_i = 32'h0000_8001; cause_i = 32'h0; timer_int_i = 1'b1;
    cycle();
    clear_inputs();
`ifdef EXC_CTRL_TIMER_INT_EN
    vectors++;
    if (excepttype_o !== 32'h1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL timer_int_taken: got exc=%h busy=%b, need 1 1", excepttype_o, busy_o);
    end
`else
    vectors++;
    if (excepttype_o !== 32'h0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL timer_int_ignored: got exc=%h busy=%b, need 0 0", excepttype_o, busy_o);
    end
`endif
    repeat (4) cycle();
    $display("timer interrupt: build-option behaviour checked");
  endtask

  initial begin
    test_reset();
    test_syscall();
    test_interrupt_priority();
    test_masked_interrupt();
    test_eret();
    test_back_to_back();
    test_reset_midflush();
    test_timer_int();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt sequencer between the MEM stage and the CP0 register file. Each cycle it samples the exception flags of the instruction in MEM plus pending interrupts qualified by CP0 Status/Cause. It picks one event by fixed priority and issues a one-cycle `excepttype_o` code to CP0. It then runs a flush-then-redirect sequence that steers the pipeline to the handler vector or to EPC.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: cycles `flush_o` is held high, legal range 1..15.
- `VEC_OFFSET`, default 12'h180: handler offset appended to EBase[31:12].

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low (rst=0 resets).
- `mem_valid_i` in 1: MEM holds a valid, non-bubble instruction.
- `exc_flags_i` in 7: {eret, ades, ov, trap, syscall, inst_invalid, adel}, bit 0 = adel.
- `inst_addr_i` in 32: PC of the MEM instruction.
- `in_delay_slot_i` in 1: MEM instruction is in a delay slot.
- `bad_addr_i` in 32: faulting address for adel/ades.
- `status_i` in 32: CP0 Status (IE=bit0, EXL=bit1, IM=bits15:8).
- `cause_i` in 32: CP0 Cause (IP=bits15:8).
- `epc_i` in 32: CP0 EPC.
- `ebase_i` in 32: CP0 EBase.
- `timer_int_i` in 1: CP0 timer interrupt.
- `excepttype_o` out 32: code to CP0, nonzero for exactly one cycle per event.
- `exc_addr_o` out 32: registered `inst_addr_i` to CP0.
- `exc_delay_slot_o` out 1: registered delay-slot flag.
- `exc_bad_addr_o` out 32: registered `bad_addr_i`.
- `flush_o` out 1: flush all pipeline stages.
- `pc_we_o` out 1: one-cycle PC load strobe.
- `new_pc_o` out 32: redirect target, valid while `pc_we_o`=1.
- `busy_o` out 1: state is not IDLE.
- `exc_count_o` out 16: events taken, saturating at 16'hFFFF.

## Operation
- States and transitions:
  - IDLE -> FLUSH when an event is detected.
  - FLUSH -> REDIRECT after `FLUSH_CYCLES` cycles.
  - REDIRECT -> IDLE after 1 cycle.
- Event detection happens only in IDLE and only when `mem_valid_i`=1. Inputs are ignored in FLUSH and REDIRECT.
- An interrupt is pending when IE=1, EXL=0 and (IP & IM) != 0.
- Priority, highest first, with the code sent:
  - interrupt 32'h1
  - adel 32'hf
  - inst_invalid 32'ha
  - syscall 32'h8
  - trap 32'hd
  - ov 32'hc
  - ades 32'hb
  - eret 32'he
- Exactly one code is issued even when several flags are set.
- On detection:
  - Register the code, `inst_addr_i`, `in_delay_slot_i` and `bad_addr_i`.
  - Record whether the event was eret.
  - Increment `exc_count_o` (holds at 16'hFFFF).
- `excepttype_o` is nonzero only in the first FLUSH cycle, and 0 at all other times.
- `flush_o`=1 in every FLUSH cycle.
- REDIRECT:
  - `pc_we_o`=1.
  - `new_pc_o` = `epc_i` for eret, else {`ebase_i`[31:12], `VEC_OFFSET`}. It is sampled in REDIRECT, after CP0 has absorbed the event.
- Outside REDIRECT, `new_pc_o`=0 and `pc_we_o`=0.

## Timing
- Reset values:
  - state IDLE
  - `excepttype_o`=0, `exc_addr_o`=0, `exc_delay_slot_o`=0, `exc_bad_addr_o`=0
  - `flush_o`=0, `pc_we_o`=0, `new_pc_o`=0, `busy_o`=0, `exc_count_o`=0
- Latency: detection at edge N. `excepttype_o` and `flush_o` are high in cycle N+1. `pc_we_o` is high in cycle N+1+`FLUSH_CYCLES`. The block is back in IDLE one cycle later.
- Back-to-back events: the earliest new detection is the cycle after REDIRECT, so at least `FLUSH_CYCLES`+2 cycles separate events.
- `busy_o` is high from N+1 through the REDIRECT cycle.
- Reset asserted mid-sequence: the block returns to IDLE immediately and all outputs go to reset values. No `pc_we_o` is issued for the aborted event, and the count is not rolled back.
- An interrupt arriving in the same cycle as eret is taken as the interrupt, not the eret.

## Configuration
- `EXC_CTRL_TIMER_INT_EN` defined: `timer_int_i` is ORed into IP7 (Cause bit 15) before masking with IM7.
- Undefined: `timer_int_i` is ignored, and only `cause_i` IP bits are used.

## Test plan
- Syscall only, `inst_addr_i`=32'h8000_0100, `ebase_i`=32'h8000_0000, default parameters:
  - `excepttype_o`=32'h8 for one cycle.
  - `flush_o` high for 2 cycles.
  - `pc_we_o` with `new_pc_o`=32'h8000_0180, 3 cycles after detection.
- Interrupt: Status=32'h0000_0401, Cause IP2=1, together with the ov flag -> code 32'h1 is issued, not 32'hc.
- Same interrupt with EXL=1 -> no event. Then with IE=0 -> no event. `busy_o` stays 0.
- eret with `epc_i`=32'h8000_0200 -> code 32'he, `new_pc_o`=32'h8000_0200.
- Second syscall presented during FLUSH -> ignored, and `exc_count_o` increments by 1 only.
- `rst` pulsed low during FLUSH -> all outputs 0 asynchronously, and no `pc_we_o` follows.
- With `EXC_CTRL_TIMER_INT_EN` defined, IM7=1 and `timer_int_i`=1 -> code 32'h1. Without the macro -> no event.
